// File: rtl/fabric_config_loader.sv
// Bitstream loader for the eFPGA fabric: syncs on a marker word, decodes frame headers,
// assembles one word per row into FrameData and pulses the matching FrameStrobe line.
module fabric_config_loader #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 6,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumColumns      = 5,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [FrameBitsPerRow-1:0]                cfg_data_i,
  input  logic                                      cfg_valid_i,
  output logic                                      cfg_ready_o,
  output logic [FrameBitsPerRow*NumRows-1:0]        frame_data_o,
  output logic [MaxFramesPerCol*NumColumns-1:0]     frame_strobe_o,
  output logic                                      configured_o,
  output logic                                      busy_o,
  output logic                                      error_o
);

  localparam int unsigned NumStrobes = MaxFramesPerCol * NumColumns;
  localparam int unsigned IdxW       = $clog2(NumStrobes);
  localparam int unsigned RowW       = $clog2(NumRows);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    DATA   = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [RowW-1:0] row_q;

  logic            accept;
  logic [1:0]      hdr_op;
  logic [7:0]      hdr_col;
  logic [7:0]      hdr_frame;
  logic            hdr_ok;
  logic [IdxW-1:0] idx_c;
  logic            sync_hit;
  logic            load_hdr;
  logic            wr_row;
  logic            set_cfg;
  logic            set_err;

  assign accept    = cfg_valid_i & cfg_ready_o;
  assign hdr_op    = cfg_data_i[31:30];
  assign hdr_col   = cfg_data_i[15:8];
  assign hdr_frame = cfg_data_i[7:0];
  assign hdr_ok    = (32'(hdr_col) < NumColumns) && (32'(hdr_frame) < MaxFramesPerCol);
  // Only consumed when hdr_ok holds, so the truncated product cannot wrap.
  assign idx_c     = IdxW'(hdr_col) * IdxW'(MaxFramesPerCol) + IdxW'(hdr_frame);

  // Next-state and control decode
  always_comb begin
    state_d  = state_q;
    sync_hit = 1'b0;
    load_hdr = 1'b0;
    wr_row   = 1'b0;
    set_cfg  = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && cfg_data_i == SyncWord) begin
          sync_hit = 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        // SyncWord decodes as op=11, so it must be filtered out as a nop first.
        if (accept && cfg_data_i != SyncWord) begin
          case (hdr_op)
            2'b00: state_d = HDR;
            2'b01: begin
              if (hdr_ok) begin
                load_hdr = 1'b1;
                state_d  = DATA;
              end else begin
                set_err = 1'b1;
                state_d = IDLE;
              end
            end
            2'b10: begin
              set_cfg = 1'b1;
              state_d = IDLE;
            end
            default: begin
              set_err = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      DATA: begin
        if (accept) begin
          wr_row = 1'b1;
          if (row_q == RowW'(NumRows - 1)) state_d = STROBE;
        end
      end
      STROBE:  state_d = HOLD;
      HOLD:    state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      row_q          <= '0;
      cfg_ready_o    <= 1'b0;
      frame_data_o   <= '0;
      frame_strobe_o <= '0;
      configured_o   <= 1'b0;
      busy_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cfg_ready_o    <= (state_d == IDLE) || (state_d == HDR) || (state_d == DATA);
      busy_o         <= (state_d != IDLE);
      frame_strobe_o <= '0;
      if (state_d == STROBE) frame_strobe_o[idx_q] <= 1'b1;
      if (load_hdr) begin
        idx_q <= idx_c;
        row_q <= '0;
      end
      if (wr_row) begin
        frame_data_o[row_q*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data_i;
        row_q <= row_q + RowW'(1);
      end
      if (sync_hit) begin
        configured_o <= 1'b0;
        error_o      <= 1'b0;
      end
      if (set_cfg) configured_o <= 1'b1;
      if (set_err) error_o      <= 1'b1;
    end
  end

endmodule
